ntt_intt_engine: RTL and testbench

NTT_INTT_ENGINE -- requirements
Module: ntt_intt_engine

---
 rtl/ntt_intt_engine.sv | 204 ++++++++++++++++++++
 tb/tb_ntt_intt_engine.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_intt_engine.sv
// Direct-form NTT / inverse NTT engine with streaming load and unload.
// One modular multiply-accumulate per cycle, twiddles generated on the fly.
module ntt_intt_engine #(
  parameter int N          = 512,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9,
  parameter int MODULUS    = 7681,
  parameter int ROOT       = 7146,
  parameter int ROOT_INV   = 7480,
  parameter int N_INV      = 7666
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam logic [PW-1:0] MOD_P = PW'(MODULUS);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;
  localparam logic [DATA_WIDTH-1:0] W_FWD = DATA_WIDTH'(ROOT);
  localparam logic [DATA_WIDTH-1:0] W_INV = DATA_WIDTH'(ROOT_INV);
  localparam logic [DATA_WIDTH-1:0] NINV = DATA_WIDTH'(N_INV);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
  localparam logic [ADDR_WIDTH-1:0] A_ONE = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE, LOAD, COMPUTE, UNLOAD
  } state_t;

  // (a*b + c) mod MODULUS; operands are residues so the sum fits PW bits
  function automatic logic [DATA_WIDTH-1:0] mac_mod(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic [DATA_WIDTH-1:0] c
  );
    logic [PW-1:0] p;
    p = PW'(a) * PW'(b) + PW'(c);
    p = p % MOD_P;
    return p[DATA_WIDTH-1:0];
  endfunction

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d;
  logic [ADDR_WIDTH-1:0] n_q, n_d;
  logic wb_q, wb_d;
  logic mode_q, mode_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] tw_q, tw_d;
  logic [DATA_WIDTH-1:0] wk_q, wk_d;
  logic out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic out_last_q, out_last_d;
  logic done_q, done_d;

  logic [DATA_WIDTH-1:0] x_mem [N];
  logic [DATA_WIDTH-1:0] y_mem [N];
  logic x_we, y_we;
  logic [DATA_WIDTH-1:0] x_wdata, y_wdata, w_sel;
  logic [PW-1:0] in_red;

  assign in_ready  = (state_q == LOAD);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign done      = done_q;

  // Next-state and datapath: load, k/n MAC sweep, then handshaked unload
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    k_d         = k_q;
    n_d         = n_q;
    wb_d        = wb_q;
    mode_d      = mode_q;
    acc_d       = acc_q;
    tw_d        = tw_q;
    wk_d        = wk_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    done_d      = 1'b0;
    x_we        = 1'b0;
    y_we        = 1'b0;
    in_red      = PW'(in_data) % MOD_P;
    x_wdata     = in_red[DATA_WIDTH-1:0];
    w_sel       = mode_q ? W_INV : W_FWD;
    y_wdata     = mode_q ? mac_mod(acc_q, NINV, ZERO) : acc_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          mode_d  = mode;
          idx_d   = '0;
        end
      end
      LOAD: begin
        if (in_valid) begin
          x_we  = 1'b1;
          idx_d = idx_q + A_ONE;
          if (idx_q == LAST) begin
            state_d = COMPUTE;
            k_d     = '0;
            n_d     = '0;
            wb_d    = 1'b0;
            acc_d   = ZERO;
            tw_d    = ONE;
            wk_d    = ONE;
          end
        end
      end
      COMPUTE: begin
        if (!wb_q) begin
          acc_d = mac_mod(x_mem[n_q], tw_q, acc_q);
          tw_d  = mac_mod(tw_q, wk_q, ZERO);
          n_d   = n_q + A_ONE;
          wb_d  = (n_q == LAST);
        end else begin
          y_we  = 1'b1;
          acc_d = ZERO;
          tw_d  = ONE;
          wk_d  = mac_mod(wk_q, w_sel, ZERO);
          n_d   = '0;
          wb_d  = 1'b0;
          k_d   = k_q + A_ONE;
          if (k_q == LAST) begin
            state_d     = UNLOAD;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_data_d  = y_mem[0];
            out_last_d  = 1'b0;
          end
        end
      end
      UNLOAD: begin
        if (out_ready) begin
          if (idx_q == LAST) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            done_d      = 1'b1;
          end else begin
            idx_d      = idx_q + A_ONE;
            out_data_d = y_mem[idx_q + A_ONE];
            out_last_d = ((idx_q + A_ONE) == LAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      k_q         <= '0;
      n_q         <= '0;
      wb_q        <= 1'b0;
      mode_q      <= 1'b0;
      acc_q       <= '0;
      tw_q        <= '0;
      wk_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      k_q         <= k_d;
      n_q         <= n_d;
      wb_q        <= wb_d;
      mode_q      <= mode_d;
      acc_q       <= acc_d;
      tw_q        <= tw_d;
      wk_q        <= wk_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      done_q      <= done_d;
    end
  end

  // Coefficient and result storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (x_we) x_mem[idx_q] <= x_wdata;
    if (y_we) y_mem[k_q] <= y_wdata;
  end

endmodule

// File: tb/tb_ntt_intt_engine.sv
// Bench for ntt_intt_engine at N=8, q=17: reference DFT model
// plus literal vectors, latency, stall, abort and round-trip runs.
module tb_ntt_intt_engine;

  localparam int N = 8;
  localparam int Q = 17;

  typedef int vec_t [N];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic mode = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] in_data = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [15:0] out_data;
  logic out_last;
  logic busy;
  logic done;

  int checks = 0;
  int errors = 0;
  vec_t exp_data;
  vec_t got;
  int beat;
  int done_cnt;

  always #5 clk = ~clk;

  ntt_intt_engine #(
    .N(8), .DATA_WIDTH(16), .ADDR_WIDTH(3),
    .MODULUS(17), .ROOT(2), .ROOT_INV(9), .N_INV(15)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done)
  );

  task automatic chk(input bit ok, input string name,
                     input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int powmod(input int b, input int e);
    int r = 1;
    for (int i = 0; i < e; i++) r = (r * b) % Q;
    return r;
  endfunction

  // Plain DFT over Z_17 straight from the definition
  function automatic vec_t model(input vec_t x, input bit inv);
    vec_t y;
    int w = inv ? 9 : 2;
    for (int k = 0; k < N; k++) begin
      int s = 0;
      for (int n = 0; n < N; n++)
        s = (s + (x[n] % Q) * powmod(w, (k * n) % N)) % Q;
      y[k] = inv ? (s * 15) % Q : s;
    end
    return y;
  endfunction

  // Output compare: data, last flag, hold under stall, done count
  initial begin : cmp
    bit hold_pend;
    int hold_data;
    bit hold_last;
    hold_pend = 0;
    hold_data = 0;
    hold_last = 0;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid) begin
        if (hold_pend) begin
          chk(out_data == 16'(hold_data), "hold_data", out_data, hold_data);
          chk(out_last == hold_last, "hold_last", out_last, hold_last);
        end
        if (out_ready) begin
          if (beat < N) begin
            chk(out_data == 16'(exp_data[beat]), "out_data",
                out_data, exp_data[beat]);
            got[beat] = out_data;
          end else begin
            chk(0, "beat_overflow", beat, N - 1);
          end
          chk(out_last == (beat == N - 1), "out_last",
              out_last, beat == N - 1);
          beat++;
        end
        hold_pend = !out_ready;
        hold_data = out_data;
        hold_last = out_last;
      end else begin
        hold_pend = 0;
      end
      if (rst_n && done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a transform and stream in the 8 coefficients
  task automatic load(input bit md, input vec_t vin);
    bit t;
    start = 1'b1;
    mode = md;
    tick();
    start = 1'b0;
    mode = ~md;
    chk(in_ready == 1'b1, "in_ready_after_start", in_ready, 1);
    chk(busy == 1'b1, "busy_in_load", busy, 1);
    for (int i = 0; i < N; i++) begin
      int guard = 0;
      in_data = 16'(vin[i]);
      in_valid = $urandom_range(0, 3) != 0;
      forever begin
        @(negedge clk);
        t = in_ready && in_valid;
        tick();
        if (t) break;
        in_valid = 1'b1;
        guard++;
        if (guard > 20) begin
          chk(0, "load_timeout", i, N);
          break;
        end
      end
    end
    in_valid = 1'b0;
    chk(in_ready == 1'b0, "in_ready_after_load", in_ready, 0);
  endtask

  task automatic run(input bit md, input vec_t vin, input bit rnd,
                     input bit chk_lat, input bit poke);
    int cnt = 0;
    exp_data = model(vin, md);
    beat = 0;
    done_cnt = 0;
    out_ready = 1'b0;
    load(md, vin);
    while (!out_valid && cnt < 200) begin
      if (poke) start = (cnt == 10);
      tick();
      cnt++;
      if (poke && cnt == 11)
        chk(busy && !in_ready, "busy_after_poke", busy, 1);
    end
    start = 1'b0;
    chk(out_valid == 1'b1, "out_valid_timeout", out_valid, 1);
    if (chk_lat) chk(cnt == N * (N + 1), "latency", cnt, N * (N + 1));
    cnt = 0;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    forever begin
      tick();
      cnt++;
      if (done || cnt > 200) break;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    chk(done == 1'b1, "done_timeout", done, 1);
    chk(out_valid == 1'b0, "valid_drop", out_valid, 0);
    out_ready = 1'b0;
    tick();
    chk(beat == N, "beats", beat, N);
    chk(done_cnt == 1, "done_count", done_cnt, 1);
    chk(!done && !busy, "idle_after", {done, busy}, 0);
  endtask

  task automatic cmp_vec(input vec_t a, input vec_t b, input string nm);
    for (int i = 0; i < N; i++) chk(a[i] == b[i], nm, a[i], b[i]);
  endtask

  initial begin
    vec_t imp, imp1, ones, spike, v, fwd, lit;
    imp   = '{1, 0, 0, 0, 0, 0, 0, 0};
    imp1  = '{0, 1, 0, 0, 0, 0, 0, 0};
    ones  = '{1, 1, 1, 1, 1, 1, 1, 1};
    spike = '{1, 2, 4, 8, 16, 15, 13, 9};

    #12;
    chk({in_ready, out_valid, out_data, out_last, busy, done} == '0,
        "reset_outputs", out_data, 0);
    rst_n = 1'b1;
    tick();
    chk(!busy && !in_ready, "idle_state", busy, 0);

    in_valid = 1'b1;
    in_data = 16'd5;
    tick();
    chk(in_ready == 1'b0, "in_ready_idle", in_ready, 0);
    in_valid = 1'b0;

    cmp_vec(model(imp, 0), ones, "model_fwd_impulse");
    cmp_vec(model(imp1, 0), spike, "model_fwd_shift");
    cmp_vec(model(ones, 1), imp, "model_inv_ones");

    run(0, imp, 0, 1, 0);
    cmp_vec(got, ones, "impulse_all_ones");
    run(0, imp1, 0, 0, 0);
    cmp_vec(got, spike, "shift_powers");
    run(1, spike, 0, 0, 0);
    cmp_vec(got, imp1, "shift_inverse");
    run(1, ones, 0, 0, 0);
    cmp_vec(got, imp, "inv_ones");
    v = ones;
    v[0] = 18;
    run(1, v, 0, 0, 0);
    cmp_vec(got, imp, "inv_ones_reduced");
    run(0, imp1, 1, 0, 0);
    cmp_vec(got, spike, "stall_run");
    run(0, imp1, 0, 0, 1);
    cmp_vec(got, spike, "start_ignored");

    load(0, imp1);
    repeat (20) tick();
    #3;
    rst_n = 1'b0;
    #1;
    chk({in_ready, out_valid, out_data, out_last, busy, done} == '0,
        "abort_outputs", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    run(0, imp, 0, 1, 0);
    cmp_vec(got, ones, "after_abort_ones");

    for (int r = 0; r < 100; r++) begin
      for (int i = 0; i < N; i++) v[i] = $urandom_range(0, 65535);
      run(0, v, r[0], 0, 0);
      fwd = got;
      run(1, fwd, r[1], 0, 0);
      for (int i = 0; i < N; i++) lit[i] = v[i] % Q;
      cmp_vec(got, lit, "round_trip");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
